adc_pattern_player: RTL and testbench

//  Parametrised, clocked successor to the baseline ADC ROM. Replays a stored ADC baseline record
//  as a valid/ready sample stream into the droop/drift-correction datapath.

---
 rtl/adc_pattern_player_if.sv | 31 +++
 rtl/adc_pattern_player.sv | 110 +++++++++++
 tb/tb_adc_pattern_player.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pattern_player_if.sv
// Control, pattern-write and sample-stream signals of the ADC pattern player.
// The master side drives control and accepts samples; the slave side is the player.
interface adc_pattern_player_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 9
);
  logic                     start;
  logic                     stop;
  logic                     loop_en;
  logic [ADDR_W-1:0]        last_addr;
  logic signed [DATA_W:0]   offset;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic                     busy;
  logic [15:0]              pass_cnt;

  modport master (
    output start, stop, loop_en, last_addr, offset, wr_en, wr_addr, wr_data, out_ready,
    input  out_valid, out_data, out_last, busy, pass_cnt
  );

  modport slave (
    input  start, stop, loop_en, last_addr, offset, wr_en, wr_addr, wr_data, out_ready,
    output out_valid, out_data, out_last, busy, pass_cnt
  );
endinterface

// File: rtl/adc_pattern_player.sv
// Replays a stored ADC record from a writable pattern RAM as a valid/ready stream,
// with signed offset injection, saturation, one-shot/loop modes and backpressure.
module adc_pattern_player #(
  parameter int    DATA_W    = 14,
  parameter int    ADDR_W    = 9,
  parameter string INIT_FILE = ""
) (
  input logic                  clk,
  input logic                  rst_n,
  adc_pattern_player_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]       last_q;
  logic signed [DATA_W:0]  off_q;
  logic [DATA_W-1:0]       mem [2**ADDR_W];
  logic [DATA_W-1:0]       rd_data_q;
  logic                    s1_vld_q, s1_last_q;
  logic                    vld_q, last_o_q;
  logic [DATA_W-1:0]       data_q;
  logic [15:0]             pass_q;

  logic                    adv, go, issue, at_last, accept;
  logic [DATA_W+1:0]       sum;
  logic [DATA_W-1:0]       sat;

  // Whole pipeline moves together whenever the output register can take a new sample.
  assign adv     = !vld_q || bus.out_ready;
  assign go      = (state_q == IDLE) && bus.start && !bus.stop;
  assign issue   = (state_q == RUN) && adv && !bus.stop;
  assign at_last = (rd_addr_q == last_q);
  assign accept  = vld_q && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: if (go) begin
        state_d   = RUN;
        rd_addr_d = '0;
      end
      RUN: begin
        if (bus.stop) begin
          state_d = DRAIN;
        end else if (issue) begin
          rd_addr_d = at_last ? '0 : rd_addr_q + 1'b1;
          if (at_last && !bus.loop_en) state_d = DRAIN;
        end
      end
      DRAIN: if (!s1_vld_q && adv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Offset is sign-extended into a two-bit-wider sum so both over- and underflow are visible.
  always_comb begin
    sum = {2'b00, rd_data_q} + {off_q[DATA_W], off_q};
    if (sum[DATA_W+1])   sat = '0;
    else if (sum[DATA_W]) sat = '1;
    else                  sat = sum[DATA_W-1:0];
  end

  // Pattern RAM: non-blocking write plus registered read gives read-before-write.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    if (issue)     rd_data_q <= mem[rd_addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      last_q    <= '0;
      off_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      vld_q     <= 1'b0;
      last_o_q  <= 1'b0;
      data_q    <= '0;
      pass_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      if (go) begin
        last_q <= bus.last_addr;
        off_q  <= bus.offset;
        pass_q <= '0;
      end else if (accept && last_o_q) begin
        pass_q <= pass_q + 16'd1;
      end
      if (adv) begin
        s1_vld_q  <= issue;
        s1_last_q <= issue && at_last;
        vld_q     <= s1_vld_q;
        last_o_q  <= s1_vld_q && s1_last_q;
        if (s1_vld_q) data_q <= sat;
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_o_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.pass_cnt  = pass_q;

endmodule

// File: tb/tb_adc_pattern_player.sv
// Directed bench for adc_pattern_player: table of offset/saturation vectors plus
// hand-written sequences for latency, looping, stop, reset, collisions and backpressure.
module tb_adc_pattern_player;
  localparam int DW = 14;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adc_pattern_player_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  adc_pattern_player #(.DATA_W(DW), .ADDR_W(AW), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct {
    logic [DW-1:0]        ram;
    logic signed [DW:0]   off;
    logic [DW-1:0]        exp;
  } vec_t;

  vec_t vecs[10];
  int   base[4];
  int   tests = 0;
  int   fails = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = DW'(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_start(input int last, input logic lp, input logic signed [DW:0] off);
    bus.last_addr = AW'(last); bus.loop_en = lp; bus.offset = off; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 50) begin tick(); n++; end
    chk(nm, bus.busy, 0);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    chk(nm, bus.out_valid, 1);
  endtask

  function automatic int pat(input int i);
    return (i * 37 + 5) & 16383;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, extra, idx, prev_v, prev_r, prev_d, bad;
    int exp6[8];
    base = '{4780, 4779, 4775, 4777};
    exp6 = '{4780, 4779, 4775, 4777, 4780, 4779, 999, 4777};
    vecs[0] = '{14'd16380, 15'sd10,    14'd16383};
    vecs[1] = '{14'd5,     -15'sd10,   14'd0};
    vecs[2] = '{14'd4780,  -15'sd3,    14'd4777};
    vecs[3] = '{14'd16383, 15'sd0,     14'd16383};
    vecs[4] = '{14'd0,     15'sd0,     14'd0};
    vecs[5] = '{14'd16383, 15'h4000,   14'd0};
    vecs[6] = '{14'd0,     15'sd16383, 14'd16383};
    vecs[7] = '{14'd100,   -15'sd100,  14'd0};
    vecs[8] = '{14'd8000,  15'sd200,   14'd8200};
    vecs[9] = '{14'd16373, 15'sd10,    14'd16383};

    bus.start = 0; bus.stop = 0; bus.loop_en = 0; bus.last_addr = '0; bus.offset = '0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.out_ready = 1;
    rst_n = 0;
    tick(); tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pass", bus.pass_cnt, 0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 4; i++) wr(i, base[i]);

    // T1: one-shot latency and sequence
    do_start(3, 1'b0, '0);
    chk("t1_lat_n", bus.out_valid, 0);
    tick();
    chk("t1_lat_n1", bus.out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", bus.out_valid, 1);
      chk("t1_data", bus.out_data, base[i]);
      chk("t1_last", bus.out_last, (i == 3));
    end
    tick();
    wait_idle("t1_busy");
    chk("t1_pass", bus.pass_cnt, 1);

    // T2: looping, then stop
    do_start(3, 1'b1, '0);
    got = 0;
    for (int n = 0; n < 100 && got < 12; n++) begin
      tick();
      if (bus.out_valid) begin
        chk("t2_data", bus.out_data, base[got % 4]);
        chk("t2_last", bus.out_last, (got % 4 == 3));
        got++;
      end
    end
    chk("t2_count", got, 12);
    tick();
    chk("t2_pass", bus.pass_cnt, 3);
    bus.stop = 1; tick(); bus.stop = 0;
    extra = 0;
    for (int n = 0; n < 6; n++) begin
      if (bus.out_valid) extra++;
      tick();
    end
    chk("t2_stop_extra_le2", (extra <= 2), 1);
    wait_idle("t2_busy");

    // T3: offset/saturation table, 1-sample one-shot records
    foreach (vecs[i]) begin
      wr(0, vecs[i].ram);
      do_start(0, 1'b0, vecs[i].off);
      wait_valid("t3_valid");
      chk("t3_data", bus.out_data, vecs[i].exp);
      chk("t3_last", bus.out_last, 1);
      tick();
      wait_idle("t3_busy");
    end

    // T5a: last_addr=0 looping, every sample is last
    wr(0, 1234);
    do_start(0, 1'b1, '0);
    got = 0;
    for (int n = 0; n < 30 && got < 5; n++) begin
      tick();
      if (bus.out_valid) begin
        chk("t5a_data", bus.out_data, 1234);
        chk("t5a_last", bus.out_last, 1);
        got++;
      end
    end
    chk("t5a_count", got, 5);
    bus.stop = 1; tick(); bus.stop = 0;
    wait_idle("t5a_busy");

    // T5b: start and stop together in IDLE
    bus.start = 1; bus.stop = 1; tick(); bus.start = 0; bus.stop = 0;
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      if (bus.busy || bus.out_valid) bad++;
      tick();
    end
    chk("t5b_no_output", bad, 0);

    // T5c: reset mid-stream, then replay from address 0
    for (int i = 0; i < 4; i++) wr(i, base[i]);
    do_start(3, 1'b1, '0);
    tick(); tick(); tick(); tick();
    #3 rst_n = 0;
    #1;
    chk("t5c_valid", bus.out_valid, 0);
    chk("t5c_data", bus.out_data, 0);
    chk("t5c_last", bus.out_last, 0);
    chk("t5c_busy", bus.busy, 0);
    chk("t5c_pass", bus.pass_cnt, 0);
    rst_n = 1;
    tick();
    do_start(3, 1'b0, '0);
    wait_valid("t5c_restart_valid");
    chk("t5c_restart_data", bus.out_data, base[0]);
    tick();
    wait_idle("t5c_busy_end");

    // T6: write colliding with read of address 2
    bus.wr_addr = AW'(2); bus.wr_data = DW'(999);
    do_start(3, 1'b1, '0);
    got = 0;
    for (int k = 1; k < 40 && got < 8; k++) begin
      tick();
      if (bus.out_valid) begin
        chk("t6_data", bus.out_data, exp6[got]);
        got++;
      end
      bus.wr_en = (k == 2);
    end
    bus.wr_en = 0;
    chk("t6_count", got, 8);
    bus.stop = 1; tick(); bus.stop = 0;
    wait_idle("t6_busy");

    // T4: 512-sample one-shot under random backpressure
    for (int i = 0; i < 512; i++) wr(i, pat(i));
    do_start(511, 1'b0, '0);
    idx = 0; prev_v = 0; prev_r = 0; prev_d = 0;
    for (int n = 0; n < 4000 && idx < 512; n++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (prev_v != 0 && prev_r == 0) begin
        chk("t4_stall_valid", bus.out_valid, 1);
        chk("t4_stall_data", bus.out_data, prev_d);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("t4_data", bus.out_data, pat(idx));
        if (idx == 511 || bus.out_last) chk("t4_last", bus.out_last, (idx == 511));
        idx++;
      end
      prev_v = int'(bus.out_valid); prev_r = int'(bus.out_ready); prev_d = int'(bus.out_data);
      tick();
    end
    bus.out_ready = 1;
    chk("t4_count", idx, 512);
    wait_idle("t4_busy");
    chk("t4_no_extra", bus.out_valid, 0);
    chk("t4_pass", bus.pass_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
